memoria_dados_parametrizada: RTL and testbench

//  Parametrised data memory for the MIPS datapath, successor to the fixed 16x32 word RAM.

---
 rtl/memoria_pkg.sv | 29 ++
 rtl/memoria_dados_parametrizada_if.sv | 29 ++
 rtl/memoria_alinhador.sv | 53 +++++
 rtl/memoria_dados_parametrizada.sv | 138 +++++++++++++
 tb/tb_memoria_dados_parametrizada.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/memoria_pkg.sv
// Shared encodings, FSM states and helpers for the parametrised MIPS data memory.
package memoria_pkg;

  typedef enum logic [1:0] {
    TAM_BYTE    = 2'b00,
    TAM_MEIA    = 2'b01,
    TAM_PALAVRA = 2'b10,
    TAM_ILEGAL  = 2'b11
  } tamanho_t;

  typedef enum logic [1:0] {
    IDLE,
    ESPERA,
    RESP
  } estado_t;

  // Command fields captured at acceptance and held for the whole access.
  typedef struct packed {
    logic     escrita;
    logic     leitura;
    tamanho_t tamanho;
    logic     sinal_ext;
  } comando_t;

  function automatic int bytes_por_palavra(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/memoria_dados_parametrizada_if.sv
// Request/response bus between the MEM stage and the data memory.
interface memoria_dados_parametrizada_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) ();

  logic              Req;
  logic              WriteMem;
  logic              ReadMem;
  logic [1:0]        Tamanho;
  logic              SinalExt;
  logic [ADDR_W-1:0] Endereco;
  logic [DATA_W-1:0] EscreveDado;
  logic [DATA_W-1:0] DadosLeitura;
  logic              Pronto;
  logic              Ocupado;
  logic              Erro;

  modport master (
    output Req, WriteMem, ReadMem, Tamanho, SinalExt, Endereco, EscreveDado,
    input  DadosLeitura, Pronto, Ocupado, Erro
  );

  modport slave (
    input  Req, WriteMem, ReadMem, Tamanho, SinalExt, Endereco, EscreveDado,
    output DadosLeitura, Pronto, Ocupado, Erro
  );

endinterface

// File: rtl/memoria_alinhador.sv
// Combinational little-endian lane alignment: byte-enables and shifted store data,
// plus extraction and sign/zero extension of load data.
module memoria_alinhador
  import memoria_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int NB     = bytes_por_palavra(DATA_W),
  localparam int OFF_W  = $clog2(NB)
) (
  input  tamanho_t          tamanho,
  input  logic [OFF_W-1:0]  offset,
  input  logic              sinal_ext,
  input  logic [DATA_W-1:0] escreve_dado,
  input  logic [DATA_W-1:0] palavra_lida,
  output logic [NB-1:0]     be,
  output logic [DATA_W-1:0] dado_escrita,
  output logic [DATA_W-1:0] dado_lido
);

  logic [NB-1:0]     be_base;
  logic [DATA_W-1:0] deslocado;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    be_base = '0;
    case (tamanho)
      TAM_BYTE:    be_base = NB'(1);
      TAM_MEIA:    be_base = NB'(3);
      TAM_PALAVRA: be_base = '1;
      default:     be_base = '0;
    endcase
  end

  assign be           = be_base << offset;
  assign dado_escrita = escreve_dado << {offset, 3'b000};
  assign deslocado    = palavra_lida >> {offset, 3'b000};

  // Word accesses are aligned (offset 0), so the shifted word is the raw word.
  always_comb begin
    dado_lido = '0;
    case (tamanho)
      TAM_BYTE:
        dado_lido = sinal_ext ? DATA_W'($signed(deslocado[7:0]))  : DATA_W'(deslocado[7:0]);
      TAM_MEIA:
        dado_lido = sinal_ext ? DATA_W'($signed(deslocado[15:0])) : DATA_W'(deslocado[15:0]);
      TAM_PALAVRA:
        dado_lido = deslocado;
      default:
        dado_lido = '0;
    endcase
  end

endmodule

// File: rtl/memoria_dados_parametrizada.sv
// Parametrised byte-addressed data memory with req/ready handshake, wait states and
// access-error detection; stalls the pipeline through Ocupado.
module memoria_dados_parametrizada
  import memoria_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input logic                          Clock,
  input logic                          Reset_n,
  memoria_dados_parametrizada_if.slave bus
);

  localparam int NB    = bytes_por_palavra(DATA_W);
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  estado_t           estado, prox_estado;
  logic [3:0]        cont, prox_cont;
  comando_t          cmd_vivo, cmd_q, cmd;
  logic [ADDR_W-1:0] end_q, endereco, indice_total;
  logic [DATA_W-1:0] dado_q, escreve_dado;
  logic [DATA_W-1:0] dados_leitura;
  logic [OFF_W-1:0]  offset;
  logic [IDX_W-1:0]  indice;
  logic              aceita, entra_resp, grava, desalinhado, erro;
  logic [NB-1:0]     be;
  logic [DATA_W-1:0] dado_escrita, dado_lido;

  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  assign cmd_vivo = '{escrita:   bus.WriteMem,
                      leitura:   bus.ReadMem,
                      tamanho:   tamanho_t'(bus.Tamanho),
                      sinal_ext: bus.SinalExt};

  // With no wait states the access completes on the acceptance edge itself,
  // so in IDLE the live inputs stand in for the not-yet-latched copy.
  assign aceita       = (estado == IDLE) && bus.Req;
  assign cmd          = (estado == IDLE) ? cmd_vivo        : cmd_q;
  assign endereco     = (estado == IDLE) ? bus.Endereco    : end_q;
  assign escreve_dado = (estado == IDLE) ? bus.EscreveDado : dado_q;

  assign offset       = endereco[OFF_W-1:0];
  assign indice_total = endereco >> OFF_W;
  assign indice       = indice_total[IDX_W-1:0];

  always_comb begin
    desalinhado = 1'b0;
    case (cmd.tamanho)
      TAM_MEIA:    desalinhado = offset[0];
      TAM_PALAVRA: desalinhado = (offset != '0);
      default:     desalinhado = 1'b0;
    endcase
    erro = (cmd.escrita == cmd.leitura) || (cmd.tamanho == TAM_ILEGAL) ||
           desalinhado || (indice_total >= ADDR_W'(DEPTH));
  end

  memoria_alinhador #(.DATA_W(DATA_W)) u_alinhador (
    .tamanho      (cmd.tamanho),
    .offset       (offset),
    .sinal_ext    (cmd.sinal_ext),
    .escreve_dado (escreve_dado),
    .palavra_lida (mem[indice]),
    .be           (be),
    .dado_escrita (dado_escrita),
    .dado_lido    (dado_lido)
  );

  // ESPERA runs until the counter, loaded with WAIT_CYCLES, has counted down to zero.
  always_comb begin
    prox_estado = estado;
    prox_cont   = cont;
    case (estado)
      IDLE:
        if (bus.Req) begin
          if (WAIT_CYCLES > 0) begin
            prox_estado = ESPERA;
            prox_cont   = 4'(WAIT_CYCLES);
          end else begin
            prox_estado = RESP;
          end
        end
      ESPERA:
        if (cont == 4'd0) prox_estado = RESP;
        else              prox_cont   = cont - 4'd1;
      RESP:    prox_estado = IDLE;
      default: prox_estado = IDLE;
    endcase
  end

  assign entra_resp = (prox_estado == RESP) && (estado != RESP);
  assign grava      = entra_resp && cmd.escrita && !erro && Reset_n;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      estado        <= IDLE;
      cont          <= '0;
      cmd_q         <= '0;
      end_q         <= '0;
      dado_q        <= '0;
      dados_leitura <= '0;
    end else begin
      estado <= prox_estado;
      cont   <= prox_cont;
      if (aceita) begin
        cmd_q  <= cmd_vivo;
        end_q  <= bus.Endereco;
        dado_q <= bus.EscreveDado;
      end
      if (entra_resp) begin
        if (erro)             dados_leitura <= '0;
        else if (cmd.leitura) dados_leitura <= dado_lido;
      end
    end
  end

  // NOTE: the array is deliberately not reset; contents survive Reset_n and only
  // the time-zero initial value is defined.
  always_ff @(posedge Clock) begin
    if (grava) begin
      for (int n = 0; n < NB; n++) begin
        if (be[n]) mem[indice][8*n +: 8] <= dado_escrita[8*n +: 8];
      end
    end
  end

  // Ocupado includes a pending Req in IDLE so the stage stalls on the request cycle
  // and stays stalled across back-to-back accesses.
  assign bus.DadosLeitura = dados_leitura;
  assign bus.Pronto       = (estado == RESP);
  assign bus.Erro         = (estado == RESP) && erro;
  assign bus.Ocupado      = (estado != IDLE) || (bus.Req && Reset_n);

endmodule

// File: tb/tb_memoria_dados_parametrizada.sv
// Self-checking bench for memoria_dados_parametrizada (DATA_W=32, DEPTH=16, WAIT_CYCLES=1).
module tb_memoria_dados_parametrizada;

  localparam int WAIT = 1;
  localparam int LAT  = WAIT + 2;

  typedef struct {
    logic        erro;
    logic        chk;
    logic [31:0] dado;
    string       nome;
  } esperado_t;

  logic      Clock = 1'b0;
  logic      Reset_n;
  int        errors = 0;
  int        checks = 0;
  int        ultima_lat;
  esperado_t sb[$];
  esperado_t mon_e;

  always #5 Clock = ~Clock;

  memoria_dados_parametrizada_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  memoria_dados_parametrizada #(
    .DATA_W(32), .DEPTH(16), .ADDR_W(32), .WAIT_CYCLES(WAIT)
  ) dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  // Scoreboard: every Pronto pulse pops the oldest expectation.
  always @(negedge Clock) begin
    if (bus.Pronto === 1'b1) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL pronto_inesperado: Pronto=1 with no access outstanding at %0t", $time);
      end else begin
        mon_e = sb.pop_front();
        checks++;
        if (bus.Erro !== mon_e.erro) begin
          errors++;
          $display("FAIL %s_erro: got %b expected %b", mon_e.nome, bus.Erro, mon_e.erro);
        end
        checks++;
        if (bus.Ocupado !== 1'b1) begin
          errors++;
          $display("FAIL %s_ocupado: got %b expected 1", mon_e.nome, bus.Ocupado);
        end
        if (mon_e.chk) begin
          checks++;
          if (bus.DadosLeitura !== mon_e.dado) begin
            errors++;
            $display("FAIL %s_dado: got %h expected %h", mon_e.nome, bus.DadosLeitura, mon_e.dado);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Drives one access, scrambles the inputs after acceptance and waits (bounded) for Pronto.
  task automatic executa(input string nome, input logic wr, input logic rd,
                         input logic [1:0] tam, input logic ext,
                         input logic [31:0] addr, input logic [31:0] dado,
                         input logic exp_erro, input logic chk, input logic [31:0] exp_dado);
    sb.push_back('{erro: exp_erro, chk: chk, dado: exp_dado, nome: nome});
    @(negedge Clock);
    bus.Req = 1'b1; bus.WriteMem = wr; bus.ReadMem = rd; bus.Tamanho = tam;
    bus.SinalExt = ext; bus.Endereco = addr; bus.EscreveDado = dado;
    @(posedge Clock); #1;
    bus.Req = 1'b0;
    bus.WriteMem = 1'($urandom); bus.ReadMem = 1'($urandom); bus.Tamanho = 2'($urandom);
    bus.SinalExt = 1'($urandom); bus.Endereco = $urandom; bus.EscreveDado = $urandom;
    ultima_lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge Clock);
      if (bus.Pronto === 1'b1) begin
        ultima_lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge Clock);
    checks++;
    if (bus.Pronto !== 1'b0)      begin errors++; $display("FAIL reset_pronto: got %b expected 0", bus.Pronto); end
    checks++;
    if (bus.Ocupado !== 1'b0)     begin errors++; $display("FAIL reset_ocupado: got %b expected 0", bus.Ocupado); end
    checks++;
    if (bus.Erro !== 1'b0)        begin errors++; $display("FAIL reset_erro: got %b expected 0", bus.Erro); end
    checks++;
    if (bus.DadosLeitura !== '0)  begin errors++; $display("FAIL reset_dado: got %h expected 0", bus.DadosLeitura); end
    Reset_n = 1'b1;
  endtask

  task automatic test_reset_mid_access();
    int pulsos = 0;
    @(negedge Clock);
    bus.Req = 1'b1; bus.WriteMem = 1'b1; bus.ReadMem = 1'b0; bus.Tamanho = 2'b10;
    bus.SinalExt = 1'b0; bus.Endereco = 32'h8; bus.EscreveDado = 32'hDEADBEEF;
    @(posedge Clock); #1;
    bus.Req = 1'b0;
    @(negedge Clock);
    checks++;
    if (bus.Ocupado !== 1'b1) begin errors++; $display("FAIL espera_ocupado: got %b expected 1", bus.Ocupado); end
    Reset_n = 1'b0;
    @(negedge Clock);
    checks++;
    if (bus.Ocupado !== 1'b0) begin errors++; $display("FAIL reset_meio_ocupado: got %b expected 0", bus.Ocupado); end
    Reset_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge Clock);
      if (bus.Pronto === 1'b1) pulsos++;
    end
    checks++;
    if (pulsos !== 0) begin errors++; $display("FAIL reset_meio_pronto: got %0d pulses expected 0", pulsos); end
    executa("load_pos_reset", 1'b0, 1'b1, 2'b10, 1'b0, 32'h8, 32'h0, 1'b0, 1'b1, 32'h00000000);
  endtask

  task automatic test_store_load();
    executa("store_word", 1'b1, 1'b0, 2'b10, 1'b0, 32'h4, 32'h12345678, 1'b0, 1'b0, 32'h0);
    checks++;
    if (ultima_lat !== LAT) begin errors++; $display("FAIL store_latencia: got %0d expected %0d", ultima_lat, LAT); end
    @(negedge Clock);
    checks++;
    if (bus.Pronto !== 1'b0) begin errors++; $display("FAIL pronto_um_ciclo: got %b expected 0", bus.Pronto); end
    executa("load_word", 1'b0, 1'b1, 2'b10, 1'b1, 32'h4, 32'h0, 1'b0, 1'b1, 32'h12345678);
    checks++;
    if (ultima_lat !== LAT) begin errors++; $display("FAIL load_latencia: got %0d expected %0d", ultima_lat, LAT); end
  endtask

  task automatic test_byte();
    executa("store_byte",    1'b1, 1'b0, 2'b00, 1'b0, 32'h5, 32'h00000080, 1'b0, 1'b0, 32'h0);
    executa("word_pos_byte", 1'b0, 1'b1, 2'b10, 1'b0, 32'h4, 32'h0, 1'b0, 1'b1, 32'h12348078);
    executa("byte_sinal",    1'b0, 1'b1, 2'b00, 1'b1, 32'h5, 32'h0, 1'b0, 1'b1, 32'hFFFFFF80);
    executa("byte_zero",     1'b0, 1'b1, 2'b00, 1'b0, 32'h5, 32'h0, 1'b0, 1'b1, 32'h00000080);
  endtask

  task automatic test_half();
    executa("store_meia",       1'b1, 1'b0, 2'b01, 1'b0, 32'h6, 32'h0000BEEF, 1'b0, 1'b0, 32'h0);
    executa("meia_sinal",       1'b0, 1'b1, 2'b01, 1'b1, 32'h6, 32'h0, 1'b0, 1'b1, 32'hFFFFBEEF);
    executa("meia_desalinhada", 1'b0, 1'b1, 2'b01, 1'b1, 32'h7, 32'h0, 1'b1, 1'b1, 32'h00000000);
    executa("word_desalinhada", 1'b1, 1'b0, 2'b10, 1'b0, 32'h6, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h0);
    executa("word_intacta",     1'b0, 1'b1, 2'b10, 1'b0, 32'h4, 32'h0, 1'b0, 1'b1, 32'hBEEF8078);
  endtask

  task automatic test_errors();
    executa("fora_faixa_load",  1'b0, 1'b1, 2'b10, 1'b0, 32'h40, 32'h0, 1'b1, 1'b1, 32'h0);
    checks++;
    if (ultima_lat !== LAT) begin errors++; $display("FAIL erro_latencia: got %0d expected %0d", ultima_lat, LAT); end
    executa("fora_faixa_store", 1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'hCAFEF00D, 1'b1, 1'b0, 32'h0);
    executa("word0_intacta",    1'b0, 1'b1, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h00000000);
    executa("wr_rd_ambos",      1'b1, 1'b1, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0);
    checks++;
    if (ultima_lat !== LAT) begin errors++; $display("FAIL cmd_latencia: got %0d expected %0d", ultima_lat, LAT); end
    executa("wr_rd_nenhum",     1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0);
    executa("tamanho_ilegal",   1'b0, 1'b1, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0);
    checks++;
    if (ultima_lat !== LAT) begin errors++; $display("FAIL tam_latencia: got %0d expected %0d", ultima_lat, LAT); end
  endtask

  task automatic test_back_to_back();
    int prontos = 0;
    for (int i = 0; i < 10; i++)
      executa("prep_b2b", 1'b1, 1'b0, 2'b10, 1'b0, 32'(4*i), 32'hA5A50000 | 32'(4*i),
              1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      @(negedge Clock);
      if (bus.Pronto === 1'b1) prontos++;
      if (i > 0) begin
        checks++;
        if (bus.Ocupado !== 1'b1) begin
          errors++; $display("FAIL b2b_ocupado: cycle %0d got %b expected 1", i, bus.Ocupado);
        end
      end
      bus.Req = 1'b1; bus.WriteMem = 1'b0; bus.ReadMem = 1'b1; bus.Tamanho = 2'b10;
      bus.SinalExt = 1'b0; bus.Endereco = 32'(4*i); bus.EscreveDado = 32'h0;
      // An idle FSM accepts on this cycle's edge, then again every WAIT+3 cycles.
      if (i % (WAIT + 3) == 0)
        sb.push_back('{erro: 1'b0, chk: 1'b1, dado: 32'hA5A50000 | 32'(4*i), nome: "b2b_load"});
    end
    @(posedge Clock); #1;
    bus.Req = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge Clock);
      if (bus.Pronto === 1'b1) prontos++;
    end
    checks++;
    if (prontos !== 3) begin errors++; $display("FAIL b2b_acessos: got %0d expected 3", prontos); end
  endtask

  initial begin
    Reset_n = 1'b0;
    bus.Req = 1'b0; bus.WriteMem = 1'b0; bus.ReadMem = 1'b0; bus.Tamanho = 2'b00;
    bus.SinalExt = 1'b0; bus.Endereco = '0; bus.EscreveDado = '0;
    repeat (2) @(negedge Clock);
    test_reset();
    test_reset_mid_access();
    test_store_load();
    test_byte();
    test_half();
    test_errors();
    test_back_to_back();
    repeat (3) @(negedge Clock);
    checks++;
    if (sb.size() !== 0) begin
      errors++; $display("FAIL scoreboard_vazio: got %0d outstanding expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
